// File: rtl/alu_pkg.sv
// Shared opcode encodings and the flag bundle used by the ALU core and its pipeline.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLL = 6'b000000;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opcode decode, result and flags for one operand set.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_SHAMT  = $clog2(NB_DATA)
) (
  input  logic [NB_DATA-1:0]   dato_a_i,
  input  logic [NB_DATA-1:0]   dato_b_i,
  input  logic [NB_OPCODE-1:0] opcode_i,
  output logic [NB_DATA-1:0]   result_o,
  output alu_flags_t           flags_o
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA:0]    sum;
  logic [NB_SHAMT-1:0] shamt;
  logic [NB_DATA-1:0]  result;
  logic                carry;
  logic                ovf;
  logic                err;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    shamt  = dato_b_i[NB_SHAMT-1:0];
    case (opcode_i)
      NB_OPCODE'(OP_ADD): begin
        sum    = {1'b0, dato_a_i} + {1'b0, dato_b_i};
        result = sum[MSB:0];
        carry  = sum[NB_DATA];
        ovf    = (dato_a_i[MSB] == dato_b_i[MSB]) && (result[MSB] != dato_a_i[MSB]);
      end
      NB_OPCODE'(OP_SUB): begin
        // Extra MSB of the widened difference is the unsigned borrow.
        sum    = {1'b0, dato_a_i} - {1'b0, dato_b_i};
        result = sum[MSB:0];
        carry  = sum[NB_DATA];
        ovf    = (dato_a_i[MSB] != dato_b_i[MSB]) && (result[MSB] != dato_a_i[MSB]);
      end
      NB_OPCODE'(OP_AND): result = dato_a_i & dato_b_i;
      NB_OPCODE'(OP_OR):  result = dato_a_i | dato_b_i;
      NB_OPCODE'(OP_XOR): result = dato_a_i ^ dato_b_i;
      NB_OPCODE'(OP_NOR): result = ~(dato_a_i | dato_b_i);
      NB_OPCODE'(OP_SRA): result = $unsigned($signed(dato_a_i) >>> shamt);
      NB_OPCODE'(OP_SRL): result = dato_a_i >> shamt;
      NB_OPCODE'(OP_SLL): result = dato_a_i << shamt;
      default:            err    = 1'b1;
    endcase
  end

  assign result_o      = result;
  assign flags_o.zero  = (result == '0);
  assign flags_o.neg   = result[MSB];
  assign flags_o.carry = carry;
  assign flags_o.ovf   = ovf;
  assign flags_o.err   = err;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds operands, S2 holds result and flags, valid/ready on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_SHAMT  = $clog2(NB_DATA)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NB_DATA-1:0]   dato_a,
  input  logic [NB_DATA-1:0]   dato_b,
  input  logic [NB_OPCODE-1:0] opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NB_DATA-1:0]   out,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 flag_carry,
  output logic                 flag_ovf,
  output logic                 err_opcode
);

  logic                 s1_valid_q, s1_valid_d;
  logic [NB_DATA-1:0]   s1_a_q, s1_a_d;
  logic [NB_DATA-1:0]   s1_b_q, s1_b_d;
  logic [NB_OPCODE-1:0] s1_op_q, s1_op_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [NB_DATA-1:0]   s2_res_q, s2_res_d;
  alu_flags_t           s2_flags_q, s2_flags_d;

  logic [NB_DATA-1:0]   core_res;
  alu_flags_t           core_flags;
  logic                 s2_load;
  logic                 s1_load;

  alu_core #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE),
    .NB_SHAMT  (NB_SHAMT)
  ) u_core (
    .dato_a_i (s1_a_q),
    .dato_b_i (s1_b_q),
    .opcode_i (s1_op_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // Ready ripples combinationally from out_ready back to in_ready; no skid buffer.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = dato_a;
        s1_b_d  = dato_b;
        s1_op_d = opcode;
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d   = core_res;
        s2_flags_d = core_flags;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; the payload is reset too so out and flags read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out        = s2_res_q;
  assign flag_zero  = s2_flags_q.zero;
  assign flag_neg   = s2_flags_q.neg;
  assign flag_carry = s2_flags_q.carry;
  assign flag_ovf   = s2_flags_q.ovf;
  assign err_opcode = s2_flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (NB_DATA=8); inputs change and outputs are sampled on the falling edge.
module tb_alu_pipe;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [NB_DATA-1:0]   dato_a;
  logic [NB_DATA-1:0]   dato_b;
  logic [NB_OPCODE-1:0] opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [NB_DATA-1:0]   out;
  logic                 flag_zero;
  logic                 flag_neg;
  logic                 flag_carry;
  logic                 flag_ovf;
  logic                 err_opcode;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dato_a     (dato_a),
    .dato_b     (dato_b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .err_opcode (err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Flag bundle as {zero, neg, carry, ovf, err}.
  function automatic logic [4:0] flags();
    return {flag_zero, flag_neg, flag_carry, flag_ovf, err_opcode};
  endfunction

  // Single op into an empty pipe with out_ready=1; verifies 2-cycle latency, result and flags.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_out, input logic [4:0] exp_fl);
    in_valid = 1'b1;
    opcode   = op;
    dato_a   = a;
    dato_b   = b;
    check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid_early"}, 16'(out_valid), 16'd0);
    @(negedge clk);
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_out"}, 16'(out), 16'(exp_out));
    check({tag, "_flags"}, 16'(flags()), 16'(exp_fl));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dato_a    = '0;
    dato_b    = '0;
    opcode    = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out", 16'(out), 16'd0);
    check("rst_flags", 16'(flags()), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'd1);

    //     tag        op   a      b      out    {z,n,c,v,e}
    run_op("add_ovf", ADD, 8'h7F, 8'h01, 8'h80, 5'b01010);
    run_op("add_cy",  ADD, 8'hFF, 8'h01, 8'h00, 5'b10100);
    run_op("sub_bor", SUB, 8'h00, 8'h01, 8'hFF, 5'b01100);
    run_op("sub_ovf", SUB, 8'h80, 8'h01, 8'h7F, 5'b00010);
    run_op("and",     AND, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    run_op("or",      OR,  8'hF0, 8'h0C, 8'hFC, 5'b01000);
    run_op("xor",     XOR, 8'hFF, 8'hFF, 8'h00, 5'b10000);
    run_op("nor",     NOR, 8'h0F, 8'hF0, 8'h00, 5'b10000);
    run_op("sra",     SRA, 8'h80, 8'h03, 8'hF0, 5'b01000);
    run_op("srl",     SRL, 8'h80, 8'h03, 8'h10, 5'b00000);
    run_op("sll",     SLL, 8'h81, 8'h0F, 8'h80, 5'b01000);
    run_op("illegal", BAD, 8'h12, 8'h34, 8'h00, 5'b10001);
    @(negedge clk);
    check("drained", 16'(out_valid), 16'd0);

    // Backpressure: three ADDs against a stalled consumer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = ADD;
    dato_a    = 8'd1;
    dato_b    = 8'd1;
    check("bp_ready0", 16'(in_ready), 16'd1);
    @(negedge clk);
    check("bp_ready1", 16'(in_ready), 16'd1);
    dato_a = 8'd2;
    dato_b = 8'd2;
    @(negedge clk);
    check("bp_ready_low", 16'(in_ready), 16'd0);
    dato_a = 8'd3;
    dato_b = 8'd3;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_out", 16'(out), 16'h02);
      check("bp_hold_ready", 16'(in_ready), 16'd0);
      @(negedge clk);
    end
    check("bp_hold_flags", 16'(flags()), 16'd0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out2_valid", 16'(out_valid), 16'd1);
    check("bp_out2", 16'(out), 16'h04);
    @(negedge clk);
    check("bp_out3_valid", 16'(out_valid), 16'd1);
    check("bp_out3", 16'(out), 16'h06);
    @(negedge clk);
    check("bp_empty", 16'(out_valid), 16'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dato_a    = 8'h05;
    dato_b    = 8'h05;
    opcode    = BAD;
    @(negedge clk);
    dato_a = 8'h06;
    dato_b = 8'h06;
    opcode = ADD;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_full_valid", 16'(out_valid), 16'd1);
    check("mr_full_err", 16'(err_opcode), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid", 16'(out_valid), 16'd0);
    check("mr_out", 16'(out), 16'd0);
    check("mr_flags", 16'(flags()), 16'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    check("mr_in_ready", 16'(in_ready), 16'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mr_no_stale", 16'(out_valid), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
